// File: rtl/key_mux_with_default.sv
// Key-matched lookup multiplexer: selects the data paired with a matching key,
// falling back to default_out. Optionally registers out/hit for pipelined use.
module key_mux_with_default #(
    parameter int unsigned NR_KEY     = 2,
    parameter int unsigned KEY_LEN    = 1,
    parameter int unsigned DATA_LEN   = 1,
    parameter int unsigned REGISTERED = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [KEY_LEN-1:0]                    key,
    input  logic [DATA_LEN-1:0]                   default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
    output logic [DATA_LEN-1:0]                   out,
    output logic                                  hit
);

    localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

    logic [DATA_LEN-1:0] sel_data;
    logic                sel_hit;

    // Scan pairs from index 0 upward; the first (lowest-index) match wins.
    always_comb begin
        sel_data = default_out;
        sel_hit  = 1'b0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (!sel_hit && (lut[i*PAIR_LEN + DATA_LEN +: KEY_LEN] == key)) begin
                sel_data = lut[i*PAIR_LEN +: DATA_LEN];
                sel_hit  = 1'b1;
            end
        end
    end

    if (REGISTERED != 0) begin : g_reg
        // One-cycle output register; reset takes priority over the load.
        always_ff @(posedge clk) begin
            if (rst) begin
                out <= '0;
                hit <= 1'b0;
            end else begin
                out <= sel_data;
                hit <= sel_hit;
            end
        end
    end else begin : g_comb
        // Zero-latency path; clock and reset have no role here.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out = sel_data;
        assign hit = sel_hit;
    end

endmodule

// File: tb/tb_key_mux_with_default.sv
// Bench for key_mux_with_default: directed combinational cases across several
// parameter sets plus a randomized registered instance checked by a scoreboard.
module tb_key_mux_with_default;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Case 1: three pairs, 7-bit keys, 32-bit data
    logic [6:0]        p1_key;
    logic [31:0]       p1_def, p1_out;
    logic [3*39-1:0]   p1_lut;
    logic              p1_hit;
    key_mux_with_default #(.NR_KEY(3), .KEY_LEN(7), .DATA_LEN(32), .REGISTERED(0)) u_p1 (
        .clk(clk), .rst(rst), .key(p1_key), .default_out(p1_def), .lut(p1_lut),
        .out(p1_out), .hit(p1_hit));

    // Case 2: four pairs
    logic [6:0]        p2_key;
    logic [31:0]       p2_def, p2_out;
    logic [4*39-1:0]   p2_lut;
    logic              p2_hit;
    key_mux_with_default #(.NR_KEY(4), .KEY_LEN(7), .DATA_LEN(32), .REGISTERED(0)) u_p2 (
        .clk(clk), .rst(rst), .key(p2_key), .default_out(p2_def), .lut(p2_lut),
        .out(p2_out), .hit(p2_hit));

    // Case 3: duplicate keys
    logic [4:0]        d_key;
    logic [7:0]        d_def, d_out;
    logic [2*13-1:0]   d_lut;
    logic              d_hit;
    key_mux_with_default #(.NR_KEY(2), .KEY_LEN(5), .DATA_LEN(8), .REGISTERED(0)) u_dup (
        .clk(clk), .rst(rst), .key(d_key), .default_out(d_def), .lut(d_lut),
        .out(d_out), .hit(d_hit));

    // Case 6: full and partial 3-bit key sweeps
    logic [2:0]        s_key;
    logic [7:0]        s_def, s8_out, s7_out;
    logic [8*11-1:0]   s8_lut;
    logic [7*11-1:0]   s7_lut;
    logic              s8_hit, s7_hit;
    key_mux_with_default #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(8), .REGISTERED(0)) u_sw8 (
        .clk(clk), .rst(rst), .key(s_key), .default_out(s_def), .lut(s8_lut),
        .out(s8_out), .hit(s8_hit));
    key_mux_with_default #(.NR_KEY(7), .KEY_LEN(3), .DATA_LEN(8), .REGISTERED(0)) u_sw7 (
        .clk(clk), .rst(rst), .key(s_key), .default_out(s_def), .lut(s7_lut),
        .out(s7_out), .hit(s7_hit));

    // Registered and combinational instances sharing random stimulus
    logic [3:0]        r_key;
    logic [31:0]       r_def, r_out, c_out;
    logic [4*36-1:0]   r_lut;
    logic              r_hit, c_hit;
    key_mux_with_default #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(32), .REGISTERED(1)) u_reg (
        .clk(clk), .rst(rst), .key(r_key), .default_out(r_def), .lut(r_lut),
        .out(r_out), .hit(r_hit));
    key_mux_with_default #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(32), .REGISTERED(0)) u_cmb (
        .clk(clk), .rst(rst), .key(r_key), .default_out(r_def), .lut(r_lut),
        .out(c_out), .hit(c_hit));

    typedef struct {
        logic [31:0] out;
        logic        hit;
    } exp_t;

    exp_t        sb_q[$];
    logic [3:0]  rk[4];
    logic [31:0] rd[4];

    // Reference: build a key->data map, inserting high indices first so lower
    // indices overwrite duplicates; then a simple lookup.
    function automatic exp_t ref_lookup(input logic [3:0] k, input logic [31:0] def);
        logic [31:0] m[int];
        exp_t e;
        for (int i = 3; i >= 0; i--) m[int'(rk[i])] = rd[i];
        if (m.exists(int'(k))) begin
            e.out = m[int'(k)];
            e.hit = 1'b1;
        end else begin
            e.out = def;
            e.hit = 1'b0;
        end
        return e;
    endfunction

    task automatic pack_reg();
        for (int i = 0; i < 4; i++) r_lut[i*36 +: 36] = {rk[i], rd[i]};
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.out = 32'h0;
        e.hit = 1'b0;
        return e;
    endfunction

    // Monitor: the registered outputs reflect one queued expectation per edge.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("reg_out", r_out, e.out);
            check("reg_hit", 32'(r_hit), 32'(e.hit));
        end
    end

    initial begin
        exp_t e;
        rst    = 1'b1;
        r_key  = '0;
        r_def  = '0;
        r_lut  = '0;
        p1_lut = {7'b0010111, 32'h80000100, 7'b0110111, 32'h0, 7'b1101111, 32'h80000100};
        p1_def = 32'h12345678;
        p2_lut = {7'b0110011, 32'hAAAA0001, 7'b1100011, 32'hAAAA0001,
                  7'b0000011, 32'h00000010, 7'b0100011, 32'h00000010};
        p2_def = 32'h00000010;
        d_lut  = {5'h3, 8'h11, 5'h3, 8'h22};
        d_def  = 8'h5A;
        d_key  = 5'h3;
        s_def  = 8'hA5;
        for (int i = 0; i < 8; i++) s8_lut[i*11 +: 11] = {3'(i), 8'(i*5)};
        for (int i = 0; i < 7; i++) s7_lut[i*11 +: 11] = {3'(i), 8'(i*5)};

        // Case 1
        p1_key = 7'b0110111; #1;
        check("p1_k37_out", p1_out, 32'h0);          check("p1_k37_hit", 32'(p1_hit), 32'd1);
        p1_key = 7'b0010111; #1;
        check("p1_k17_out", p1_out, 32'h80000100);   check("p1_k17_hit", 32'(p1_hit), 32'd1);
        p1_key = 7'b0010011; #1;
        check("p1_miss_out", p1_out, 32'h12345678);  check("p1_miss_hit", 32'(p1_hit), 32'd0);

        // Case 2
        p2_key = 7'b1100011; #1;
        check("p2_k63_out", p2_out, 32'hAAAA0001);   check("p2_k63_hit", 32'(p2_hit), 32'd1);
        p2_key = 7'b0100011; #1;
        check("p2_k23_out", p2_out, 32'h10);         check("p2_k23_hit", 32'(p2_hit), 32'd1);
        p2_key = 7'b1110011; #1;
        check("p2_miss_out", p2_out, 32'h10);        check("p2_miss_hit", 32'(p2_hit), 32'd0);

        // Case 3: lowest index wins
        #1;
        check("dup_out", 32'(d_out), 32'h22);        check("dup_hit", 32'(d_hit), 32'd1);

        // Case 6: sweep
        for (int k = 0; k < 8; k++) begin
            s_key = 3'(k); #1;
            check("sw8_out", 32'(s8_out), 32'(8'(k*5)));
            check("sw8_hit", 32'(s8_hit), 32'd1);
            if (k < 7) begin
                check("sw7_out", 32'(s7_out), 32'(8'(k*5)));
                check("sw7_hit", 32'(s7_hit), 32'd1);
            end else begin
                check("sw7_def_out", 32'(s7_out), 32'hA5);
                check("sw7_def_hit", 32'(s7_hit), 32'd0);
            end
        end

        // Case 4: reset, then a matching key loads after exactly one edge
        for (int i = 0; i < 4; i++) begin
            rk[i] = 4'(i + 1);
            rd[i] = 32'(i) + 32'h100;
        end
        rd[2] = 32'hDEADBEEF;
        rk[2] = 4'h9;
        @(negedge clk);
        rst = 1'b1; pack_reg(); r_key = 4'h0; r_def = 32'h0BAD0BAD;
        sb_q.push_back(reset_exp());
        @(negedge clk);
        rst = 1'b0; r_key = 4'h9;
        sb_q.push_back(ref_lookup(r_key, r_def));
        #1;
        check("reg_hold_out", r_out, 32'h0);
        check("reg_hold_hit", 32'(r_hit), 32'd0);
        check("reg_deadbeef_model", ref_lookup(r_key, r_def).out, 32'hDEADBEEF);

        // Case 5: reset coincides with a matching key
        @(negedge clk);
        rst = 1'b1; r_key = 4'h9;
        sb_q.push_back(reset_exp());
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(ref_lookup(r_key, r_def));

        // Randomized traffic, keys drawn often from the table to force hits
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rk[i] = 4'($urandom_range(0, 15));
                rd[i] = $urandom;
            end
            if (($urandom & 1) != 0) rk[$urandom_range(0, 3)] = rk[$urandom_range(0, 3)];
            pack_reg();
            r_def = $urandom;
            r_key = (($urandom % 3) != 0) ? rk[$urandom_range(0, 3)] : 4'($urandom_range(0, 15));
            rst   = (($urandom % 16) == 0);
            e = ref_lookup(r_key, r_def);
            sb_q.push_back(rst ? reset_exp() : e);
            #1;
            check("cmb_out", c_out, e.out);
            check("cmb_hit", 32'(c_hit), 32'(e.hit));
        end

        // Drain scoreboard with a bounded wait
        rst = 1'b0;
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
        #2;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
